// File: rtl/decode_regfile.sv
// decode_regfile: serialized decode stage with an 8-entry register file.
// Ports: clk/rst, instr handshake, direct load, ALU operands/result, writeback, debug read.
module decode_regfile #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 5,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] ALU_out,
  output logic              wb_done,
  output logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;

  logic [DATA_W-1:0] regs [8];
  logic [2:0]        rd_q;

  logic [2:0] f_rs;
  logic [2:0] f_rt;
  logic [2:0] f_rd;

  assign f_rs = instr[13:11];
  assign f_rt = instr[10:8];
  assign f_rd = instr[7:5];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // r0 is never written, but the read path forces zero as well
  assign rs_val = (f_rs == 3'd0) ? '0 : regs[f_rs];
  assign rt_val = (f_rt == 3'd0) ? '0 : regs[f_rt];

  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

  assign instr_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opcode    <= '0;
      rs_data   <= '0;
      rt_data   <= '0;
      immediate <= '0;
      wb_data   <= '0;
      wb_done   <= 1'b0;
      rd_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          wb_done <= 1'b0;
          // an accepted instruction wins over a same-cycle load
          if (instr_valid) begin
            opcode    <= OP_W'(instr[16:14]);
            immediate <= IMM_W'(instr[4:0]);
            rs_data   <= rs_val;
            rt_data   <= rt_val;
            rd_q      <= f_rd;
            state     <= EXEC;
          end else if (load_en && (load_addr != 3'd0)) begin
            regs[load_addr] <= load_data;
          end
        end
        EXEC: begin
          wb_data <= ALU_out;
          wb_done <= 1'b1;
          state   <= WB;
        end
        WB: begin
          wb_done <= 1'b0;
          if (rd_q != 3'd0) begin
            regs[rd_q] <= wb_data;
          end
          state <= IDLE;
        end
        default: begin
          wb_done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed scoreboard bench for decode_regfile.
// Stimulus pushes expected operands/results; a monitor pops and compares.
`timescale 1ns/1ps
module tb_decode_regfile;

  logic        clk;
  logic        rst;
  logic [16:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [15:0] load_data;
  logic [2:0]  opcode;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [4:0]  immediate;
  logic [15:0] ALU_out;
  logic        wb_done;
  logic [15:0] wb_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  decode_regfile dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data),
    .opcode(opcode), .rs_data(rs_data),
    .rt_data(rt_data), .immediate(immediate),
    .ALU_out(ALU_out),
    .wb_done(wb_done), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [4:0]  imm;
  } op_exp_t;

  op_exp_t     opq [$];
  logic [15:0] wbq [$];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rdchk(input logic [2:0] a,
                       input logic [15:0] exp);
    dbg_addr = a;
    #0.5;
    chk($sformatf("dbg_r%0d", a), dbg_data, exp);
  endtask

  task automatic load(input logic [2:0] a,
                      input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic expect_op(input logic [2:0] op,
                           input logic [15:0] ers,
                           input logic [15:0] ert,
                           input logic [4:0] imm);
    op_exp_t e;
    e.op  = op;
    e.rs  = ers;
    e.rt  = ert;
    e.imm = imm;
    opq.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [2:0] rs,
                       input logic [2:0] rt,
                       input logic [2:0] rd,
                       input logic [4:0] imm,
                       input logic [15:0] alu,
                       input logic [15:0] ers,
                       input logic [15:0] ert,
                       input bit push_wb);
    expect_op(op, ers, ert, imm);
    if (push_wb) wbq.push_back(alu);
    ALU_out     = alu;
    instr       = {op, rs, rt, rd, imm};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_wb(input logic [15:0] exp);
    chk("ready_exec", instr_ready, 0);
    chk("wbdone_exec", wb_done, 0);
    step();
    chk("wbdone_wb", wb_done, 1);
    chk("wbdata_wb", wb_data, exp);
    chk("ready_wb", instr_ready, 0);
    step();
    load_en = 1'b0;
    chk("wbdone_after", wb_done, 0);
    chk("ready_after", instr_ready, 1);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_wbdone"}, wb_done, 0);
    chk({tag, "_opcode"}, opcode, 0);
    chk({tag, "_rs"}, rs_data, 0);
    chk({tag, "_rt"}, rt_data, 0);
    chk({tag, "_imm"}, immediate, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    for (int a = 0; a < 8; a++) rdchk(3'(a), 16'h0);
  endtask

  // Monitor: samples just before each rising edge
  initial begin
    bit pend;
    op_exp_t e;
    logic [15:0] w;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      #9;
      if (pend) begin
        if (opq.size() == 0) begin
          chk("op_unexpected", 1, 0);
        end else begin
          e = opq.pop_front();
          chk("mon_opcode", opcode, e.op);
          chk("mon_rs_data", rs_data, e.rs);
          chk("mon_rt_data", rt_data, e.rt);
          chk("mon_immediate", immediate, e.imm);
        end
      end
      if (wb_done) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          w = wbq.pop_front();
          chk("mon_wb_data", wb_data, w);
        end
      end
      pend = instr_valid && instr_ready && !rst;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    ALU_out = '0; dbg_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    zero_outs("rst");

    load(3'd1, 16'h1234);
    load(3'd2, 16'h0F0F);
    rdchk(3'd1, 16'h1234);
    rdchk(3'd2, 16'h0F0F);

    issue(3'd2, 3'd1, 3'd2, 3'd3, 5'd7,
          16'hABCD, 16'h1234, 16'h0F0F, 1);
    wait_wb(16'hABCD);
    rdchk(3'd3, 16'hABCD);
    step();
    chk("hold_opcode", opcode, 2);
    chk("hold_rs", rs_data, 16'h1234);
    chk("hold_rt", rt_data, 16'h0F0F);
    chk("hold_imm", immediate, 7);

    issue(3'd1, 3'd3, 3'd0, 3'd0, 5'd31,
          16'hFFFF, 16'hABCD, 16'h0000, 1);
    wait_wb(16'hFFFF);
    rdchk(3'd0, 16'h0);
    load(3'd0, 16'h7777);
    rdchk(3'd0, 16'h0);

    issue(3'd5, 3'd2, 3'd1, 3'd7, 5'd3,
          16'h0BAD, 16'h0F0F, 16'h1234, 1);
    load_en = 1'b1; load_addr = 3'd5;
    load_data = 16'h5555;
    wait_wb(16'h0BAD);
    rdchk(3'd5, 16'h0);
    rdchk(3'd7, 16'h0BAD);

    load_en = 1'b1; load_addr = 3'd1;
    load_data = 16'h9999;
    issue(3'd6, 3'd5, 3'd7, 3'd2, 5'd4,
          16'h0042, 16'h0000, 16'h0BAD, 1);
    load_en = 1'b0;
    wait_wb(16'h0042);
    rdchk(3'd1, 16'h1234);
    rdchk(3'd2, 16'h0042);

    // back-to-back with instr_valid held high
    expect_op(3'd3, 16'h1234, 16'h1234, 5'd1);
    wbq.push_back(16'h1111);
    ALU_out = 16'h1111;
    instr = {3'd3, 3'd1, 3'd1, 3'd4, 5'd1};
    instr_valid = 1'b1;
    step();
    expect_op(3'd4, 16'h1111, 16'hABCD, 5'd2);
    wbq.push_back(16'h2222);
    instr = {3'd4, 3'd4, 3'd3, 3'd6, 5'd2};
    chk("b2b_ready1", instr_ready, 0);
    step();
    ALU_out = 16'h2222;
    chk("b2b_ready2", instr_ready, 0);
    chk("b2b_wbdone_a", wb_done, 1);
    step();
    chk("b2b_ready3", instr_ready, 1);
    rdchk(3'd4, 16'h1111);
    step();
    chk("b2b_ready4", instr_ready, 0);
    instr_valid = 1'b0;
    step();
    chk("b2b_wbdone_b", wb_done, 1);
    chk("b2b_wbdata_b", wb_data, 16'h2222);
    step();
    chk("b2b_ready5", instr_ready, 1);
    rdchk(3'd6, 16'h2222);

    // reset while in EXEC
    issue(3'd7, 3'd1, 3'd1, 3'd3, 5'd0,
          16'hDEAD, 16'h1234, 16'h1234, 0);
    rst = 1'b1;
    chk("rstx_wbdone0", wb_done, 0);
    step();
    chk("rstx_wbdone1", wb_done, 0);
    step();
    rst = 1'b0;
    chk("rstx_wbdone2", wb_done, 0);
    step();
    zero_outs("rstx");

    repeat (3) step();
    chk("opq_empty", opq.size(), 0);
    chk("wbq_empty", wbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
